// File: rtl/scan_decoder_pkg.sv
// decoder_pkg: FSM state type, mode encodings and the one-hot helper shared
// by the scan_decoder slice.
package decoder_pkg;

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN, BLANK} state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest select the helper supports; callers cast their select up to this.
   localparam int unsigned ONEHOT_MAX_SEL_W = 6;

   function automatic logic [(1 << ONEHOT_MAX_SEL_W)-1:0] onehot(
      input logic [ONEHOT_MAX_SEL_W-1:0] sel
   );
      logic [(1 << ONEHOT_MAX_SEL_W)-1:0] v;
      v = '0;
      v[0] = 1'b1;
      return v << sel;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and strobe outputs of scan_decoder.
// master drives the controls (board logic / bench), slave is the decoder.
interface scan_decoder_if #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8
);
   localparam int OUT_N = 1 << SEL_W;

   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   a;
   logic               load;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_N-1:0]   b;
   logic [SEL_W-1:0]   idx;
   logic               wrap;

   modport master (
      output en, mode, a, load, dwell,
      input  b, idx, wrap
   );

   modport slave (
      input  en, mode, a, load, dwell,
      output b, idx, wrap
   );
endinterface

// File: rtl/scan_decoder_onehot_decode.sv
// onehot_decode: combinational select -> one-hot decode with enable;
// all-zero output when disabled.
module onehot_decode
   import decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                    i_en,
   input  logic [SEL_W-1:0]        i_sel,
   output logic [(1 << SEL_W)-1:0] o_y
);
   localparam int OUT_N = 1 << SEL_W;

   always_comb begin
      o_y = '0;
      if (i_en) begin
         o_y = OUT_N'(onehot(ONEHOT_MAX_SEL_W'(i_sel)));
      end
   end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// Define SCAN_DECODER_BLANK_EN to insert a 1-cycle blank between scanned lines.
module scan_decoder
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   scan_decoder_if.slave bus
);
   localparam int OUT_N = 1 << SEL_W;
   localparam logic [SEL_W-1:0] LAST_IDX = '1;

   state_t             r_state, w_state_nxt;
   logic [DWELL_W-1:0] r_cnt,   w_cnt_nxt;
   logic [SEL_W-1:0]   r_idx,   w_idx_nxt;
   logic               r_wrap,  w_wrap_nxt;
   logic [OUT_N-1:0]   r_b,     w_b_nxt;
   logic               w_b_en;

   // b is always onehot(next idx) or blank, so one decoder feeds the register.
   onehot_decode #(.SEL_W(SEL_W)) u_dec (
      .i_en  (w_b_en),
      .i_sel (w_idx_nxt),
      .o_y   (w_b_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_wrap_nxt  = 1'b0;
      w_b_en      = 1'b0;
      if (!bus.en) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else if (bus.mode == MODE_DIRECT) begin
         w_state_nxt = DIRECT;
         w_cnt_nxt   = '0;
         w_b_en      = 1'b1;
         if (r_state != DIRECT || bus.load) begin
            w_idx_nxt = bus.a;
         end
      end else begin
         w_b_en = 1'b1;
         case (r_state)
            IDLE: begin
               w_state_nxt = SCAN;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
            end
            DIRECT: begin
               w_state_nxt = SCAN;
               w_cnt_nxt   = '0;
            end
            SCAN: begin
               if (r_cnt != bus.dwell) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end else begin
                  w_cnt_nxt = '0;
`ifdef SCAN_DECODER_BLANK_EN
                  w_state_nxt = BLANK;
                  w_b_en      = 1'b0;
`else
                  w_idx_nxt  = r_idx + 1'b1;
                  w_wrap_nxt = (r_idx == LAST_IDX);
`endif
               end
            end
            BLANK: begin
               w_state_nxt = SCAN;
               w_idx_nxt   = r_idx + 1'b1;
               w_wrap_nxt  = (r_idx == LAST_IDX);
            end
            default: begin
               w_state_nxt = IDLE;
               w_b_en      = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wrap  <= 1'b0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_wrap  <= w_wrap_nxt;
         r_b     <= w_b_nxt;
      end
   end

   assign bus.b    = r_b;
   assign bus.idx  = r_idx;
   assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed and random checks of scan_decoder against a
// line-period arithmetic model (SEL_W=2, DWELL_W=8).
module tb_scan_decoder;
   localparam int SEL_W   = 2;
   localparam int DWELL_W = 8;
`ifdef SCAN_DECODER_BLANK_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

   scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: kind 0=idle 1=direct 2=scan; scan position is k cycles since entry.
   int       m_kind = 0;
   int       m_idx  = 0;
   int       m_base = 0;
   int       m_k    = 0;
   logic [3:0] e_b    = '0;
   logic       e_wrap = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int p;
      int line;
      if (!bus.en) begin
         m_kind = 0;
         e_b    = '0;
         e_wrap = 1'b0;
      end else if (bus.mode == 1'b0) begin
         if (m_kind != 1 || bus.load) m_idx = int'(bus.a);
         m_kind = 1;
         e_b    = 4'(1 << m_idx);
         e_wrap = 1'b0;
      end else begin
         if (m_kind != 2) begin
            m_base = (m_kind == 1) ? m_idx : 0;
            m_k    = 0;
            m_kind = 2;
         end else begin
            m_k++;
         end
         p      = int'(bus.dwell) + 1 + EXTRA;
         line   = (m_base + m_k / p) % 4;
         m_idx  = line;
         e_b    = (EXTRA == 1 && (m_k % p) == p - 1) ? 4'b0000 : 4'(1 << line);
         e_wrap = (m_k > 0 && (m_k % p) == 0 && line == 0);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      model_step();
      check({tag, ".b"},       32'(bus.b),    32'(e_b));
      check({tag, ".idx"},     32'(bus.idx),  32'(m_idx));
      check({tag, ".wrap"},    32'(bus.wrap), 32'(e_wrap));
      check({tag, ".onehot0"}, 32'($onehot0(bus.b)), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int wraps;
      rst_n     = 1'b0;
      bus.en    = 1'b0;
      bus.mode  = 1'b0;
      bus.a     = '0;
      bus.load  = 1'b0;
      bus.dwell = '0;
      #1;
      check("rst.b",    32'(bus.b),    32'h0);
      check("rst.idx",  32'(bus.idx),  32'h0);
      check("rst.wrap", 32'(bus.wrap), 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick("idle");
      tick("idle");

      // DIRECT capture, hold, blank on disable
      bus.en = 1'b1; bus.mode = 1'b0; bus.a = 2'd2; bus.load = 1'b1;
      tick("dir_load");
      check("dir_load_lit", 32'(bus.b), 32'h4);
      bus.a = 2'd3; bus.load = 1'b0;
      tick("dir_hold");
      check("dir_hold_lit", 32'(bus.b), 32'h4);
      bus.en = 1'b0;
      tick("dir_off");
      check("dir_off_b",   32'(bus.b),   32'h0);
      check("dir_off_idx", 32'(bus.idx), 32'h2);

      // SCAN with dwell=2
      bus.dwell = 8'd2;
      tick("cfg2");
      bus.en = 1'b1; bus.mode = 1'b1;
      wraps = 0;
      for (int i = 0; i < 13; i++) begin
         tick("scan2");
         wraps += int'(bus.wrap);
      end
`ifndef SCAN_DECODER_BLANK_EN
      check("scan2_wraps",  32'(wraps),  32'd1);
      check("scan2_last_b", 32'(bus.b), 32'h1);
`endif

      // asynchronous reset mid-scan, no clock edge
      tick("pre_rst");
      #3 rst_n = 1'b0;
      #1;
      check("async_rst.b",    32'(bus.b),    32'h0);
      check("async_rst.idx",  32'(bus.idx),  32'h0);
      check("async_rst.wrap", 32'(bus.wrap), 32'h0);
      m_kind = 0; m_idx = 0;
      bus.en = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick("post_rst");

      // outputs hold until en is sampled, then dwell=0 rotation
      bus.dwell = 8'd0; bus.en = 1'b1; bus.mode = 1'b1;
      #2;
      check("hold_until_en", 32'(bus.b), 32'h0);
      wraps = 0;
      for (int i = 0; i < 12; i++) begin
         tick("scan0");
         wraps += int'(bus.wrap);
      end
`ifndef SCAN_DECODER_BLANK_EN
      check("scan0_wraps", 32'(wraps), 32'd2);
`endif

      // mode switch at idx=2
      bus.en = 1'b0;
      tick("cfg_sw");
      bus.dwell = 8'd2; bus.en = 1'b1; bus.mode = 1'b1;
      for (int i = 0; i < 40 && !(m_idx == 2 && e_b != 0); i++) tick("scan_to2");
      check("reach_idx2", 32'(bus.idx), 32'h2);
      bus.a = 2'd1; bus.mode = 1'b0;
      tick("sw_dir");
      check("sw_dir_lit", 32'(bus.b), 32'h2);
      bus.mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("sw_back");
         check("sw_back_lit", 32'(bus.b), 32'h2);
      end
      tick("sw_adv");
`ifndef SCAN_DECODER_BLANK_EN
      check("sw_adv_lit", 32'(bus.b), 32'h4);
`endif

`ifdef SCAN_DECODER_BLANK_EN
      begin
         logic [3:0] seq [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                                  4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
         bus.en = 1'b0;
         tick("cfg_blank");
         bus.dwell = 8'd1; bus.en = 1'b1; bus.mode = 1'b1;
         for (int i = 0; i < 13; i++) begin
            tick("blank_seq");
            check("blank_seq_lit", 32'(bus.b), 32'(seq[i]));
         end
      end
`endif

      // random traffic; dwell only changes while disabled
      for (int i = 0; i < 400; i++) begin
         if (bus.en == 1'b0) begin
            bus.dwell = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 3) != 0) bus.en = 1'b1;
         end else if ($urandom_range(0, 29) == 0) begin
            bus.en = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
         bus.a    = 2'($urandom);
         bus.load = 1'($urandom_range(0, 1));
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
